// File: rtl/alu_wb.sv
// ============================================================================
// alu_wb : ALU writeback stage with 2-entry result FIFO, flags register and
//          head-of-queue forwarding path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_wb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wr_en,
  input  logic              in_flags_en,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_z,
  output logic              flag_n,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        count
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              overflow;
    logic [ADDR_W-1:0] dest;
    logic              wr_en;
    logic              flags_en;
  } entry_t;

  entry_t      mem_q [2];
  entry_t      mem_d [2];
  entry_t      head;
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [1:0]  count_q, count_d;
  logic        c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic        head_valid;
  logic        accept;
  logic        retire;

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    c_d        = c_q;
    v_d        = v_q;
    z_d        = z_q;
    n_d        = n_q;
    head       = mem_q[rptr_q];
    head_valid = (count_q != 2'd0);
    // in_ready depends on registered count only, so a full FIFO refuses input
    // even in a cycle where it also retires.
    accept     = in_valid && (count_q != 2'd2);
    retire     = head_valid && (!head.wr_en || rf_ready);

    if (accept) begin
      mem_d[wptr_q] = '{result:   in_result,
                        carry:    in_carry,
                        overflow: in_overflow,
                        dest:     in_dest,
                        wr_en:    in_wr_en,
                        flags_en: in_flags_en};
      wptr_d = ~wptr_q;
    end

    if (retire) begin
      rptr_d = ~rptr_q;
      if (head.flags_en) begin
        c_d = head.carry;
        v_d = head.overflow;
        z_d = (head.result == '0);
        n_d = head.result[DATA_W-1];
      end
    end

    case ({accept, retire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  // Payload storage needs no reset: it is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    mem_q[0] <= mem_d[0];
    mem_q[1] <= mem_d[1];
  end

  assign in_ready  = (count_q != 2'd2);
  assign rf_we     = head_valid && head.wr_en && rf_ready;
  assign rf_waddr  = head.dest;
  assign rf_wdata  = head.result;
  assign fwd_valid = head_valid && head.wr_en;
  assign fwd_addr  = head.dest;
  assign fwd_data  = head.result;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_wb.sv
// ============================================================================
// tb_alu_wb : self-checking bench for alu_wb against a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_wb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_result = '0;
  logic              in_carry = 1'b0;
  logic              in_overflow = 1'b0;
  logic [ADDR_W-1:0] in_dest = '0;
  logic              in_wr_en = 1'b0;
  logic              in_flags_en = 1'b0;
  logic              rf_ready = 1'b0;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              flag_c, flag_v, flag_z, flag_n;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [1:0]        count;

  alu_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow),
    .in_dest(in_dest), .in_wr_en(in_wr_en), .in_flags_en(in_flags_en),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DATA_W-1:0] res;
    logic              c;
    logic              v;
    logic [ADDR_W-1:0] d;
    logic              wr;
    logic              fl;
  } ent_t;

  ent_t q[$];
  logic m_c = 1'b0, m_v = 1'b0, m_z = 1'b0, m_n = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_c = 1'b0; m_v = 1'b0; m_z = 1'b0; m_n = 1'b0;
    end else begin
      int    sz;
      ent_t  e;
      sz = q.size();
      if (sz > 0 && (!q[0].wr || rf_ready)) begin
        if (q[0].fl) begin
          m_c = q[0].c;
          m_v = q[0].v;
          m_z = (q[0].res == 16'h0000);
          m_n = (q[0].res >= 16'h8000);
        end
        void'(q.pop_front());
      end
      if (in_valid && sz < 2) begin
        e.res = in_result; e.c = in_carry; e.v = in_overflow;
        e.d = in_dest; e.wr = in_wr_en; e.fl = in_flags_en;
        q.push_back(e);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic hv;
    hv = (q.size() > 0);
    check("count",    {30'd0, count},      q.size());
    check("in_ready", {31'd0, in_ready},   {31'd0, q.size() < 2});
    check("rf_we",    {31'd0, rf_we},      {31'd0, hv && q[0].wr && rf_ready});
    check("fwd_valid",{31'd0, fwd_valid},  {31'd0, hv && q[0].wr});
    check("flags",    {28'd0, flag_c, flag_v, flag_z, flag_n}, {28'd0, m_c, m_v, m_z, m_n});
    if (hv) begin
      check("rf_waddr", {29'd0, rf_waddr}, {29'd0, q[0].d});
      check("rf_wdata", {16'd0, rf_wdata}, {16'd0, q[0].res});
      check("fwd_addr", {29'd0, fwd_addr}, {29'd0, q[0].d});
      check("fwd_data", {16'd0, fwd_data}, {16'd0, q[0].res});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic c, input logic ov,
                       input logic [2:0] d, input logic wr, input logic fl);
    in_valid = v; in_result = r; in_carry = c; in_overflow = ov;
    in_dest = d; in_wr_en = wr; in_flags_en = fl;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    drive(0, 16'h0, 0, 0, 0, 0, 0);
    rf_ready = 1'b0;
    #12;
    check("rst_count",    {30'd0, count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_rf_we",    {31'd0, rf_we}, 32'd0);
    check("rst_fwd",      {31'd0, fwd_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single op: result 0, carry 1 -> C=1 V=0 Z=1 N=0
    rf_ready = 1'b1;
    drive(1, 16'h0000, 1, 0, 3'd3, 1, 1);
    tick();
    idle();
    @(negedge clk);
    check("single_rf_we",  {31'd0, rf_we}, 32'd1);
    check("single_waddr",  {29'd0, rf_waddr}, 32'd3);
    check("single_wdata",  {16'd0, rf_wdata}, 32'h0000);
    tick();
    @(negedge clk);
    check("single_flags",  {28'd0, flag_c, flag_v, flag_z, flag_n}, 32'b1010);
    check("single_count",  {30'd0, count}, 32'd0);

    // Backpressure: fill with rf_ready low, third push refused
    rf_ready = 1'b0;
    tick();
    drive(1, 16'h8001, 0, 0, 3'd1, 1, 1);
    tick();
    drive(1, 16'h0002, 0, 0, 3'd2, 1, 0);
    tick();
    drive(1, 16'h1234, 0, 0, 3'd5, 1, 1);
    @(negedge clk);
    check("bp_count",    {30'd0, count}, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("bp_refused",  {30'd0, count}, 32'd2);
    tick();
    rf_ready = 1'b1;
    @(negedge clk);
    check("bp_wr1_addr", {29'd0, rf_waddr}, 32'd1);
    check("bp_wr1_data", {16'd0, rf_wdata}, 32'h8001);
    tick();
    @(negedge clk);
    check("bp_wr2_addr", {29'd0, rf_waddr}, 32'd2);
    check("bp_n_after1", {31'd0, flag_n}, 32'd1);
    tick();
    @(negedge clk);
    check("bp_drained",  {30'd0, count}, 32'd0);
    check("bp_n_held",   {31'd0, flag_n}, 32'd1);

    // Flags-only entry retires with rf_ready low
    rf_ready = 1'b0;
    drive(1, 16'h7FFF, 0, 1, 3'd6, 0, 1);
    tick();
    idle();
    @(negedge clk);
    check("fo_rf_we", {31'd0, rf_we}, 32'd0);
    check("fo_fwd",   {31'd0, fwd_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("fo_count", {30'd0, count}, 32'd0);
    check("fo_flags", {28'd0, flag_c, flag_v, flag_z, flag_n}, 32'b0100);

    // Streaming: 10 back-to-back pushes
    rf_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'h1000 + 16'(i), 0, 0, 3'(i), 1, 1);
      tick();
      @(negedge clk);
      check("stream_count", {31'd0, count > 2'd1}, 32'd0);
      check("stream_we",    {31'd0, rf_we}, 32'd1);
      check("stream_data",  {16'd0, rf_wdata}, 32'h1000 + 32'(i));
    end
    idle();
    tick();
    tick();

    // Full and retire in the same cycle
    rf_ready = 1'b0;
    drive(1, 16'hA0A0, 1, 0, 3'd4, 1, 1);
    tick();
    drive(1, 16'hB0B0, 1, 1, 3'd5, 1, 1);
    tick();
    drive(1, 16'hC0C0, 1, 0, 3'd7, 1, 1);
    rf_ready = 1'b1;
    @(negedge clk);
    check("far_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("far_count1",   {30'd0, count}, 32'd1);
    check("far_ready1",   {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    rf_ready = 1'b0;
    @(negedge clk);
    check("far_accepted", {16'd0, fwd_data}, 32'hC0C0);
    tick();
    drive(1, 16'hD0D0, 1, 0, 3'd1, 1, 1);
    tick();
    idle();
    @(negedge clk);
    check("ar_pre_count", {30'd0, count}, 32'd2);

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", {30'd0, count}, 32'd0);
    check("ar_flags", {28'd0, flag_c, flag_v, flag_z, flag_n}, 32'd0);
    check("ar_rf_we", {31'd0, rf_we}, 32'd0);
    rf_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ar_no_write", {31'd0, rf_we}, 32'd0);
      tick();
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom));
      if (($urandom & 3) == 0) drive(in_valid, 16'h0000, in_carry, in_overflow, in_dest, in_wr_en, in_flags_en);
      rf_ready = 1'($urandom_range(0, 99) < 55);
      tick();
    end
    idle();
    rf_ready = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_wb.md
Name: alu_wb

Overview:
Writeback stage directly downstream of the 16-bit ALU. It accepts each ALU result with its carry/overflow, destination register and enables through a valid/ready handshake, and buffers up to two results in a 2-entry FIFO. Results retire in order into the register-file write port and the architectural flags register (C, V, Z, N). The FIFO head is exposed as a forwarding path for operand bypass into the ALU inputs.

Parameters:
DATA_W, 16, datapath width; matches ALU result width
ADDR_W, 3, register-file address width (8 registers)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU result presented
in_ready  output  1  stage can accept this cycle
in_result  input  DATA_W  ALU result
in_carry  input  1  ALU carry
in_overflow  input  1  ALU overflow
in_dest  input  ADDR_W  destination register
in_wr_en  input  1  write result to register file
in_flags_en  input  1  update flags from this result
rf_ready  input  1  register file accepts a write this cycle
rf_we  output  1  register-file write strobe
rf_waddr  output  ADDR_W  write address
rf_wdata  output  DATA_W  write data
flag_c, flag_v, flag_z, flag_n  output  1 each  architectural flags
fwd_valid  output  1  head entry pending with in_wr_en=1
fwd_addr  output  ADDR_W  head destination
fwd_data  output  DATA_W  head result
count  output  2  entries held (0..2)

Behaviour:
- Reset (rst_n low, asynchronous): count=0, FIFO pointers=0, all flags=0, rf_we=0, fwd_valid=0, in_ready=1. An in-flight accept or retire in the reset cycle is discarded.
- Storage: 2 entries of {result, carry, overflow, dest, wr_en, flags_en}; 1-bit read/write pointers that wrap 1->0.
- Accept: in_valid && in_ready. Write entry at wptr; wptr toggles.
- in_ready = (count != 2), a function of registered count only. There is no combinational path from rf_ready to in_ready, so a full FIFO refuses input even in a cycle where it retires.
- Head: entry at rptr, valid when count != 0.
- Retire condition: head valid && (!head.wr_en || rf_ready). Flags-only entries (wr_en=0) retire without waiting for rf_ready.
- rf_we = head valid && head.wr_en && rf_ready (combinational). rf_waddr = head.dest; rf_wdata = head.result, driven whenever the head is valid. rf_we is never asserted for wr_en=0 entries.
- On retire with head.flags_en=1, flags register at the next edge:
  - C = carry
  - V = overflow
  - Z = (result == 0)
  - N = result[DATA_W-1]
  With flags_en=0, flags hold.
- On retire, rptr toggles.
- Count update:
  - +1 on accept only
  - -1 on retire only
  - unchanged on simultaneous accept and retire (count 1 stays 1; count 0 cannot retire)
- Latency: an entry accepted at edge t is head-visible after edge t if the FIFO was empty. Earliest rf_we is the cycle after acceptance; earliest flag update is at edge t+1.
- Ordering: strictly in order; register and flag updates occur in acceptance order.
- Forwarding: fwd_valid = head valid && head.wr_en. fwd_addr/fwd_data mirror the head. The second entry is not forwarded; the consumer must stall on a dest match with count==2.
- Sustained throughput is 1 result/cycle with rf_ready held high.
- When rf_ready stays low, the FIFO fills, in_ready drops, and contents hold indefinitely.

Test Plan:
- Reset then single op: in_result=0x0000, carry=1, overflow=0, dest=3, wr_en=1, flags_en=1, rf_ready=1 -> next cycle rf_we=1, waddr=3, wdata=0x0000; then C=1, V=0, Z=1, N=0; count returns to 0.
- Backpressure: rf_ready=0, push 0x8001 (dest 1) and 0x0002 (dest 2) -> count=2, in_ready=0, a third push is refused. Raise rf_ready -> writes to 1 then 2 in order, and N=1 after the first.
- Flags-only entry: wr_en=0, flags_en=1, result 0x7FFF, overflow=1, rf_ready=0 -> retires without rf_we; V=1, Z=0, N=0.
- Streaming: 10 back-to-back pushes with rf_ready=1 -> one rf_we per cycle, count never exceeds 1, data matches in order.
- Full-and-retire same cycle: count=2, rf_ready=1, in_valid=1 -> input not accepted that cycle (in_ready=0); count becomes 1, and the push is accepted the next cycle.
- Async reset mid-operation: count=2, assert rst_n=0 between edges -> count=0, flags=0, rf_we=0 immediately; no writes after release until new input.
